// File: rtl/ahb_memmap_cfg_pkg.sv
// Shared definitions for the programmable memory map:
// CTRL bit positions, register offsets and the per-window config bundle.
package ahb_memmap_cfg_pkg;

  localparam int unsigned PA_MAX = 32;

  localparam int unsigned CTRL_W     = 5;
  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_LOCK  = 1;
  localparam int unsigned CTRL_CACHE = 2;
  localparam int unsigned CTRL_IDEM  = 3;
  localparam int unsigned CTRL_EXEC  = 4;

  localparam int unsigned ST_WERR    = 0;
  localparam int unsigned ST_LOCKALL = 1;

  localparam logic [11:0] STATUS_OFS = 12'h100;

  typedef enum logic [1:0] {
    REG_BASE  = 2'd0,
    REG_RANGE = 2'd1,
    REG_CTRL  = 2'd2,
    REG_NONE  = 2'd3
  } win_reg_e;

  typedef struct packed {
    logic [PA_MAX-1:0] base;
    logic [PA_MAX-1:0] range;
    logic [CTRL_W-1:0] ctrl;
  } region_cfg_t;

  function automatic logic is_status(input logic [11:2] a);
    return a == STATUS_OFS[11:2];
  endfunction

endpackage

// File: rtl/ahb_memmap_cfg_match.sv
// Combinational window compare for every region plus a
// lowest-index-wins priority encoder.
module memmap_match
  import ahb_memmap_cfg_pkg::*;
#(
  parameter int unsigned NREGIONS = 8,
  parameter int unsigned PA_BITS  = 32,
  parameter int unsigned IW       = 3
) (
  input  logic [PA_BITS-1:0]  i_adr,
  input  region_cfg_t         i_cfg [NREGIONS],
  output logic [NREGIONS-1:0] o_vec,
  output logic [IW-1:0]       o_idx,
  output logic [2:0]          o_attr,
  output logic                o_hit
);

  logic [NREGIONS-1:0] w_unused_lock;

  always_comb begin
    o_vec = '0;
    w_unused_lock = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      w_unused_lock[i] = i_cfg[i].ctrl[CTRL_LOCK];
      o_vec[i] = i_cfg[i].ctrl[CTRL_EN] &
        ((i_adr & ~i_cfg[i].range[PA_BITS-1:0]) ==
         (i_cfg[i].base[PA_BITS-1:0] &
          ~i_cfg[i].range[PA_BITS-1:0]));
    end
  end

  // Scan downward so the lowest matching index is the last write.
  always_comb begin
    o_idx  = '0;
    o_attr = '0;
    for (int i = NREGIONS - 1; i >= 0; i--) begin
      if (o_vec[i]) begin
        o_idx  = IW'(i);
        o_attr = i_cfg[i].ctrl[CTRL_EXEC:CTRL_CACHE];
      end
    end
  end

  assign o_hit = |o_vec;

endmodule

// File: rtl/ahb_memmap_cfg.sv
// AHB-Lite slave register file holding the runtime memory map,
// with a registered lookup port for the bus decoder / PMA checker.
module ahb_memmap_cfg
  import ahb_memmap_cfg_pkg::*;
#(
  parameter int unsigned NREGIONS = 8,
  parameter int unsigned PA_BITS  = 32,
  parameter logic [NREGIONS-1:0][PA_BITS-1:0] RST_BASE  = '0,
  parameter logic [NREGIONS-1:0][PA_BITS-1:0] RST_RANGE = '0,
  parameter logic [NREGIONS-1:0][4:0]         RST_CTRL  = '0,
  localparam int unsigned IW =
    (NREGIONS > 1) ? $clog2(NREGIONS) : 1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSELCfg,
  input  logic [11:0]         HADDR,
  input  logic                HWRITE,
  input  logic [1:0]          HTRANS,
  input  logic                HREADY,
  input  logic [31:0]         HWDATA,
  output logic [31:0]         HRDATA,
  output logic                HREADYCfg,
  output logic                HRESPCfg,
  input  logic                LookupValid,
  input  logic [PA_BITS-1:0]  LookupAdr,
  output logic                HitValid,
  output logic [NREGIONS-1:0] HitVec,
  output logic [IW-1:0]       HitIdx,
  output logic [2:0]          HitAttr,
  output logic                Miss
);

  logic [PA_BITS-1:0] r_base  [NREGIONS];
  logic [PA_BITS-1:0] r_range [NREGIONS];
  logic [4:0]         r_ctrl  [NREGIONS];
  logic               r_werr;
  logic               r_lockall;

  logic               r_dp_act;
  logic               r_dp_wr;
  logic [11:2]        r_dp_addr;

  logic [PA_BITS-1:0] w_base_n  [NREGIONS];
  logic [PA_BITS-1:0] w_range_n [NREGIONS];
  logic [4:0]         w_ctrl_n  [NREGIONS];
  logic               w_werr_n;
  logic               w_lockall_n;

  logic               w_ap_act;
  logic               w_ap_inwin;
  logic [IW-1:0]      w_ap_idx;
  win_reg_e           w_ap_reg;
  logic [31:0]        w_rd;

  logic               w_dp_we;
  logic               w_dp_inwin;
  logic [IW-1:0]      w_dp_idx;
  win_reg_e           w_dp_reg;
  logic [PA_BITS-1:0] w_wdata;
  logic               w_thermo;

  region_cfg_t        w_cfg [NREGIONS];
  logic [NREGIONS-1:0] w_vec;
  logic [IW-1:0]      w_idx;
  logic [2:0]         w_attr;
  logic               w_hit;
  logic               w_unused;

  assign HREADYCfg = 1'b1;
  assign HRESPCfg  = 1'b0;
  assign w_unused  = ^{HADDR[1:0], HTRANS[0]};

  assign w_ap_act   = HSELCfg & HTRANS[1] & HREADY;
  assign w_ap_idx   = HADDR[4 +: IW];
  assign w_ap_reg   = win_reg_e'(HADDR[3:2]);
  assign w_ap_inwin = (HADDR[11:8] == 4'h0) &&
                      (32'(HADDR[7:4]) < NREGIONS);

  assign w_dp_we    = r_dp_act & r_dp_wr;
  assign w_dp_idx   = r_dp_addr[4 +: IW];
  assign w_dp_reg   = win_reg_e'(r_dp_addr[3:2]);
  assign w_dp_inwin = (r_dp_addr[11:8] == 4'h0) &&
                      (32'(r_dp_addr[7:4]) < NREGIONS);

  assign w_wdata  = HWDATA[PA_BITS-1:0];
  assign w_thermo =
    ((w_wdata & (w_wdata + PA_BITS'(1))) == '0);

  // Next-state of the register file after this cycle's write.
  always_comb begin
    w_base_n    = r_base;
    w_range_n   = r_range;
    w_ctrl_n    = r_ctrl;
    w_werr_n    = r_werr;
    w_lockall_n = r_lockall;
    if (w_dp_we) begin
      if (is_status(r_dp_addr)) begin
        if (HWDATA[ST_WERR])    w_werr_n    = 1'b0;
        if (HWDATA[ST_LOCKALL]) w_lockall_n = 1'b1;
      end else if (w_dp_inwin && w_dp_reg != REG_NONE) begin
        if (r_ctrl[w_dp_idx][CTRL_LOCK] || r_lockall) begin
          w_werr_n = 1'b1;
        end else begin
          unique case (w_dp_reg)
            REG_BASE:  w_base_n[w_dp_idx] = w_wdata;
            REG_RANGE: begin
              if (w_thermo) w_range_n[w_dp_idx] = w_wdata;
              else          w_werr_n = 1'b1;
            end
            REG_CTRL:  w_ctrl_n[w_dp_idx] = HWDATA[4:0];
            default:   ;
          endcase
        end
      end
    end
  end

  // Reads see the post-write state so a write is forwarded.
  always_comb begin
    w_rd = '0;
    if (is_status(HADDR[11:2])) begin
      w_rd[ST_WERR]    = w_werr_n;
      w_rd[ST_LOCKALL] = w_lockall_n;
    end else if (w_ap_inwin) begin
      unique case (w_ap_reg)
        REG_BASE:  w_rd = 32'(w_base_n[w_ap_idx]);
        REG_RANGE: w_rd = 32'(w_range_n[w_ap_idx]);
        REG_CTRL:  w_rd = {27'b0, w_ctrl_n[w_ap_idx]};
        default:   w_rd = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < NREGIONS; i++) begin
        r_base[i]  <= RST_BASE[i];
        r_range[i] <= RST_RANGE[i];
        r_ctrl[i]  <= RST_CTRL[i];
      end
      r_werr    <= 1'b0;
      r_lockall <= 1'b0;
      r_dp_act  <= 1'b0;
      r_dp_wr   <= 1'b0;
      r_dp_addr <= '0;
      HRDATA    <= '0;
    end else begin
      r_base    <= w_base_n;
      r_range   <= w_range_n;
      r_ctrl    <= w_ctrl_n;
      r_werr    <= w_werr_n;
      r_lockall <= w_lockall_n;
      if (HREADY) begin
        r_dp_act <= w_ap_act;
        if (w_ap_act) begin
          r_dp_wr   <= HWRITE;
          r_dp_addr <= HADDR[11:2];
        end
      end
      if (w_ap_act && !HWRITE) HRDATA <= w_rd;
    end
  end

  // Lookup compares against the map as it stands this cycle.
  always_comb begin
    for (int i = 0; i < NREGIONS; i++) begin
      w_cfg[i] = '0;
      w_cfg[i].base[PA_BITS-1:0]  = r_base[i];
      w_cfg[i].range[PA_BITS-1:0] = r_range[i];
      w_cfg[i].ctrl               = r_ctrl[i];
    end
  end

  memmap_match #(
    .NREGIONS (NREGIONS),
    .PA_BITS  (PA_BITS),
    .IW       (IW)
  ) u_match (
    .i_adr  (LookupAdr),
    .i_cfg  (w_cfg),
    .o_vec  (w_vec),
    .o_idx  (w_idx),
    .o_attr (w_attr),
    .o_hit  (w_hit)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HitValid <= 1'b0;
      HitVec   <= '0;
      HitIdx   <= '0;
      HitAttr  <= '0;
      Miss     <= 1'b0;
    end else begin
      HitValid <= LookupValid;
      Miss     <= LookupValid & ~w_hit;
      if (LookupValid) begin
        HitVec  <= w_vec;
        HitIdx  <= w_idx;
        HitAttr <= w_attr;
      end
    end
  end

endmodule

// File: tb/tb_ahb_memmap_cfg.sv
// Scoreboard bench for ahb_memmap_cfg: transaction-level map model,
// directed scenarios plus randomized bus and lookup traffic.
module tb_ahb_memmap_cfg;

  localparam int NR = 8;

  localparam logic [NR-1:0][31:0] RB = {
    32'h0, 32'h8000_0000, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0000_1000};
  localparam logic [NR-1:0][31:0] RR = {
    32'h0, 32'h0000_FFFF, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0000_0FFF};
  localparam logic [NR-1:0][4:0] RC = {
    5'h0, 5'h05, 5'h0, 5'h0,
    5'h0, 5'h0, 5'h0, 5'h01};

  typedef struct packed {
    logic [7:0] vec;
    logic [2:0] idx;
    logic [2:0] attr;
    logic       miss;
  } lk_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELCfg;
  logic [11:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYCfg;
  logic        HRESPCfg;
  logic        LookupValid;
  logic [31:0] LookupAdr;
  logic        HitValid;
  logic [7:0]  HitVec;
  logic [2:0]  HitIdx;
  logic [2:0]  HitAttr;
  logic        Miss;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_base  [NR];
  logic [31:0] m_range [NR];
  logic [4:0]  m_ctrl  [NR];
  logic        m_werr;
  logic        m_lockall;

  bit          pend_w;
  logic [11:0] pend_a;
  logic [31:0] pend_d;

  logic [31:0] rdq [$];
  lk_t         lkq [$];

  ahb_memmap_cfg #(
    .NREGIONS  (NR),
    .PA_BITS   (32),
    .RST_BASE  (RB),
    .RST_RANGE (RR),
    .RST_CTRL  (RC)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSELCfg     (HSELCfg),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HWDATA      (HWDATA),
    .HRDATA      (HRDATA),
    .HREADYCfg   (HREADYCfg),
    .HRESPCfg    (HRESPCfg),
    .LookupValid (LookupValid),
    .LookupAdr   (LookupAdr),
    .HitValid    (HitValid),
    .HitVec      (HitVec),
    .HitIdx      (HitIdx),
    .HitAttr     (HitAttr),
    .Miss        (Miss)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i]  = RB[i];
      m_range[i] = RR[i];
      m_ctrl[i]  = RC[i];
    end
    m_werr    = 1'b0;
    m_lockall = 1'b0;
  endfunction

  function automatic bit is_thermo(input logic [31:0] d);
    for (int k = 0; k <= 32; k++)
      if (64'(d) == (64'd1 << k) - 64'd1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mdl_write(input logic [11:0] a,
                                    input logic [31:0] d);
    int w;
    int s;
    w = int'(a[7:4]);
    s = int'(a[3:2]);
    if (a[11:2] == 10'h040) begin
      if (d[0]) m_werr = 1'b0;
      if (d[1]) m_lockall = 1'b1;
    end else if (a[11:8] == 4'h0 && w < NR && s < 3) begin
      if (m_ctrl[w][1] || m_lockall) m_werr = 1'b1;
      else if (s == 0) m_base[w] = d;
      else if (s == 1) begin
        if (is_thermo(d)) m_range[w] = d;
        else m_werr = 1'b1;
      end else m_ctrl[w] = d[4:0];
    end
  endfunction

  function automatic logic [31:0] mdl_read(input logic [11:0] a);
    int w;
    int s;
    w = int'(a[7:4]);
    s = int'(a[3:2]);
    if (a[11:2] == 10'h040) return {30'b0, m_lockall, m_werr};
    if (a[11:8] == 4'h0 && w < NR) begin
      if (s == 0) return m_base[w];
      if (s == 1) return m_range[w];
      if (s == 2) return {27'b0, m_ctrl[w]};
    end
    return 32'h0;
  endfunction

  // A window spans [base with range bits cleared, that + range].
  function automatic lk_t lk_expect(input logic [31:0] a);
    lk_t e;
    longint unsigned lo;
    longint unsigned hi;
    bit found;
    e = '0;
    found = 1'b0;
    for (int i = 0; i < NR; i++) begin
      lo = 64'(m_base[i] & ~m_range[i]);
      hi = lo + 64'(m_range[i]);
      if (m_ctrl[i][0] && 64'(a) >= lo && 64'(a) <= hi) begin
        e.vec[i] = 1'b1;
        if (!found) begin
          found  = 1'b1;
          e.idx  = 3'(i);
          e.attr = m_ctrl[i][4:2];
        end
      end
    end
    e.miss = !found;
    return e;
  endfunction

  task automatic cycle(input bit xa, input bit wr,
                       input logic [11:0] a, input logic [31:0] d,
                       input bit lv, input logic [31:0] la);
    HSELCfg     = xa;
    HTRANS      = xa ? 2'b10 : 2'b00;
    HWRITE      = wr;
    HADDR       = a;
    HWDATA      = pend_d;
    LookupValid = lv;
    LookupAdr   = la;
    if (lv) lkq.push_back(lk_expect(la));
    if (pend_w) mdl_write(pend_a, pend_d);
    if (xa && !wr) rdq.push_back(mdl_read(a));
    pend_w = xa && wr;
    pend_a = a;
    pend_d = d;
    @(negedge HCLK);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [11:0] a);
    cycle(1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic lk(input logic [31:0] la);
    cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, la);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    HRESETn     = 1'b0;
    HSELCfg     = 1'b0;
    HTRANS      = 2'b00;
    LookupValid = 1'b0;
    HWDATA      = pend_d;
    pend_w      = 1'b0;
    mdl_reset();
    repeat (n) @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents data.
  initial begin
    bit   rd_ph;
    lk_t  got;
    lk_t  exp;
    logic [31:0] ed;
    forever begin
      @(posedge HCLK);
      rd_ph = HRESETn && HSELCfg && HTRANS[1] && HREADY && !HWRITE;
      #1;
      if (rd_ph) begin
        checks++;
        if (rdq.size() == 0) begin
          errors++;
          $display("FAIL read: unexpected data %08h", HRDATA);
        end else begin
          ed = rdq.pop_front();
          if (HRDATA !== ed) begin
            errors++;
            $display("FAIL read: HRDATA %08h expected %08h", HRDATA, ed);
          end
        end
        chk("resp", {30'b0, HRESPCfg, HREADYCfg}, 32'h1);
      end
      if (HitValid) begin
        got = {HitVec, HitIdx, HitAttr, Miss};
        checks++;
        if (lkq.size() == 0) begin
          errors++;
          $display("FAIL lookup: unexpected HitValid vec %02h", HitVec);
        end else begin
          exp = lkq.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL lookup: vec %02h idx %0d attr %0d miss %0b expected vec %02h idx %0d attr %0d miss %0b",
                     got.vec, got.idx, got.attr, got.miss,
                     exp.vec, exp.idx, exp.attr, exp.miss);
          end
        end
      end
    end
  end

  initial begin
    bit          xa;
    bit          w;
    bit          lv;
    int          win;
    int          sub;
    logic [11:0] a;
    logic [31:0] d;
    logic [31:0] la;

    HRESETn = 1'b0; HSELCfg = 1'b0; HADDR = '0; HWRITE = 1'b0;
    HTRANS = 2'b00; HREADY = 1'b1; HWDATA = '0;
    LookupValid = 1'b0; LookupAdr = '0;
    pend_w = 1'b0; pend_a = '0; pend_d = '0;
    @(negedge HCLK);
    do_reset(2);
    @(posedge HCLK);
    #1;
    chk("rst_hitvalid", {31'b0, HitValid}, 32'h0);
    chk("rst_hitvec", {24'b0, HitVec}, 32'h0);
    chk("rst_hitidx", {29'b0, HitIdx}, 32'h0);
    chk("rst_hitattr", {29'b0, HitAttr}, 32'h0);
    chk("rst_miss", {31'b0, Miss}, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);

    lk(32'h0000_1ABC);
    lk(32'h0000_2000);
    lk(32'h8000_1234);
    idle();

    wr(12'h030, 32'h1000_0000);
    wr(12'h034, 32'h0000_0007);
    wr(12'h038, 32'h0000_001F);
    wr(12'h030, 32'h0000_0000);
    rd(12'h100);
    rd(12'h030);
    lk(32'h1000_0005);
    lk(32'h1000_0008);

    wr(12'h024, 32'h0000_0F0F);
    rd(12'h024);
    rd(12'h100);
    wr(12'h100, 32'h0000_0001);
    rd(12'h100);
    rd(12'h0FC);
    wr(12'h20C, 32'hFFFF_FFFF);
    rd(12'h20C);

    wr(12'h010, 32'h0000_2000);
    wr(12'h014, 32'h0000_00FF);
    wr(12'h018, 32'h0000_000D);
    wr(12'h050, 32'h0000_2000);
    wr(12'h054, 32'h0000_0FFF);
    wr(12'h058, 32'h0000_0011);
    idle();
    lk(32'h0000_2004);
    lk(32'h0000_2104);

    wr(12'h020, 32'h0000_3000);
    wr(12'h024, 32'h0000_000F);
    idle();
    wr(12'h028, 32'h0000_0001);
    cycle(1'b1, 1'b0, 12'h028, 32'h0, 1'b1, 32'h0000_3004);
    lk(32'h0000_3004);
    idle();

    for (int n = 0; n < 400; n++) begin
      xa  = ($urandom_range(0, 3) != 0);
      w   = 1'($urandom_range(0, 1));
      win = $urandom_range(0, 16);
      sub = $urandom_range(0, 3);
      a   = (win == 16) ? 12'h100 : {4'h0, 4'(win), 2'(sub), 2'b00};
      d   = $urandom;
      if (win == 16) d = d & 32'h1;
      else if (sub == 0) d = d & 32'h0003_F000;
      else if (sub == 1 && $urandom_range(0, 3) != 0)
        d = 32'((64'd1 << $urandom_range(0, 16)) - 64'd1);
      else if (sub == 2 && $urandom_range(0, 9) != 0) d[1] = 1'b0;
      lv = 1'($urandom_range(0, 1));
      la = $urandom;
      if ($urandom_range(0, 3) != 0)
        la = m_base[$urandom_range(0, NR - 1)] +
             32'($urandom_range(0, 32'h1FFF));
      cycle(xa, w, a, d, lv, la);
    end
    idle();

    wr(12'h100, 32'h0000_0002);
    rd(12'h100);
    wr(12'h000, 32'h0000_5555);
    rd(12'h000);
    rd(12'h100);
    wr(12'h100, 32'h0000_0002);
    do_reset(1);
    for (int i = 0; i < NR; i++) begin
      rd(12'(i * 16));
      rd(12'(i * 16 + 4));
      rd(12'(i * 16 + 8));
    end
    rd(12'h100);
    lk(32'h0000_1ABC);
    lk(32'h8000_1234);
    lk(32'h0000_2004);
    idle();
    idle();

    chk("rdq_drained", 32'(rdq.size()), 32'h0);
    chk("lkq_drained", 32'(lkq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
